sdram_ctrl_param: RTL and testbench
===================================

Name: sdram_ctrl_param

Overview:
Parametrised, timing-configurable SDRAM command controller between the single-master HSEL/HWRITE bus and the SDRAM model interface.
- Closed-page policy: every access is ACT → READ/WRITE → PRECHARGE.
- Generalised data, row, column and bank widths.
- Programmable tRCD, CAS latency, tWR, tRP and tRFC.
- Built-in periodic auto-refresh.
- All outputs registered; no latches.

Parameters:
DATA_W, 32, bus and SDRAM data width
ADDR_W, 32, in_HADDR width; must be ≥ ROW_W+BANK_W+COL_W
ROW_W, 14, row address width; also out_sdram_addr width
BANK_W, 2, bank select width
COL_W, 9, column width; must be ≤ ROW_W
T_RCD, 2, ACT-to-READ/WRITE cycles (1..255)
CAS_LAT, 2, READ command to data-valid cycles (1..255)
T_WR, 2, NOP cycles after WRITE before PRECHARGE (1..255)
T_RP, 2, PRECHARGE-to-next-command cycles (1..255)
T_RFC, 7, REFRESH-to-next-command cycles (1..255)
REF_INTERVAL, 780, cycles between refresh requests (≥ 2)

Ports:
in_HCLK  in  1  clock, rising edge
in_HRESETn  in  1  asynchronous, active-low reset
in_HSEL  in  1  transfer request
in_HWRITE  in  1  1 = write, 0 = read
in_HADDR  in  ADDR_W  byte address
in_HWDATA  in  DATA_W  write data, sampled at acceptance
out_HREADY  out  1  1 = idle, request can be accepted
out_HRDATA  out  DATA_W  read data, held until next read capture
in_sdram_read_data  in  DATA_W  SDRAM read data
out_CS  out  1  chip select, active low
out_RAS  out  1  row address strobe, active low
out_CAS  out  1  column address strobe, active low
out_write_en  out  1  write enable, active low
out_bank_select  out  BANK_W  bank
out_sdram_addr  out  ROW_W  row address, or column address zero-extended
out_sdram_write_data  out  DATA_W  write data
out_ref_busy  out  1  refresh sequence in progress

Behaviour:
- Reset (asynchronous, immediate, including mid-operation):
  - Outputs: out_CS=out_RAS=out_CAS=out_write_en=1 (DESELECT); out_bank_select=0; out_sdram_addr=0; out_sdram_write_data=0; out_HRDATA=0; out_HREADY=1; out_ref_busy=0.
  - Internals: state=IDLE; refresh counter=REF_INTERVAL-1; ref_pending=0.
  - No completion occurs for an interrupted access.
- Address decode:
  - row = HADDR[ROW_W-1:0]
  - bank = HADDR[ROW_W+BANK_W-1:ROW_W]
  - col = next COL_W bits
  - Upper bits are ignored.
- Commands as {CS,RAS,CAS,WE}: DESELECT 1111; NOP 0111; ACT 0011; READ 0101; WRITE 0100; PRECHARGE 0010 with out_sdram_addr[10]=1 (all banks); REFRESH 0001.
  - IDLE drives DESELECT.
  - All wait states drive NOP.
- Acceptance: at a rising edge where in_HSEL=1 and out_HREADY=1.
  - in_HADDR, in_HWRITE and in_HWDATA are latched.
  - out_HREADY drops at the same edge.
  - in_HSEL while out_HREADY=0 is ignored (no queueing).
  - Cycle n below means the period after acceptance edge n.
- States: IDLE, ACT, RCD_WAIT, RD_CMD, CL_WAIT, WR_CMD, WR_WAIT, PRE, RP_WAIT, REF, RFC_WAIT.
  - A single 8-bit wait counter times all delays.
- Read sequence:
  - ACT in cycle 0 (row, bank).
  - NOP in cycles 1..T_RCD-1.
  - READ in cycle T_RCD (column, bank).
  - NOP through cycle T_RCD+CAS_LAT.
  - in_sdram_read_data captured into out_HRDATA at edge T_RCD+CAS_LAT+1.
  - PRECHARGE in that cycle, then T_RP-1 NOPs.
  - IDLE with out_HREADY=1 at edge T_RCD+CAS_LAT+T_RP+1 (defaults: edge 7).
- Write sequence:
  - ACT in cycle 0; NOP in cycles 1..T_RCD-1.
  - WRITE in cycle T_RCD, with out_sdram_write_data = latched HWDATA valid in that cycle and held afterwards.
  - T_WR NOPs.
  - PRECHARGE in cycle T_RCD+T_WR+1, then T_RP-1 NOPs.
  - out_HREADY=1 at edge T_RCD+T_WR+T_RP+1 (defaults: edge 7).
- Refresh:
  - The counter decrements every cycle in every state.
  - At 0 it reloads REF_INTERVAL-1 and sets ref_pending.
  - A second expiry while pending is absorbed; ref_pending stays 1.
  - ref_pending=1 while in IDLE forces out_HREADY=0 at the same edge.
  - In IDLE, ref_pending has priority over in_HSEL.
  - REFRESH cycle clears ref_pending, then T_RFC-1 NOPs, then IDLE with out_HREADY=1.
  - out_ref_busy=1 from the REFRESH cycle through the last NOP.
- Simultaneous events:
  - Expiry on the same edge as an acceptance: the access completes first, then the refresh is issued directly from IDLE with no out_HREADY pulse in between.
- No request ever issues READ/WRITE to an open row of a different bank (closed-page).

Test Plan:
- Reset: assert in_HRESETn=0 mid-read at cycle 3 → outputs go to DESELECT/0 and out_HREADY=1 immediately, without a clock edge; after release, an idle bus shows no commands until refresh.
- Default read: HADDR=0x01A58ABC, HWRITE=0, SDRAM returns 0xDEADBEEF in cycle 4 → ACT row 0x0ABC bank 2 in cycle 0; READ col 0x1A5 in cycle 2; out_HRDATA=0xDEADBEEF at edge 5; PRECHARGE in cycle 5 with addr[10]=1; out_HREADY=1 at edge 7.
- Default write: HADDR=0x00030005, HWDATA=0x12345678, HWRITE=1 → ACT row 5 bank 0 in cycle 0; WRITE col 3 in cycle 2 with data 0x12345678; PRECHARGE in cycle 5; out_HREADY=1 at edge 7.
- Refresh priority: REF_INTERVAL=20, idle with in_HSEL held 1 at expiry → out_HREADY drops; REFRESH 0001 issued; out_ref_busy high 7 cycles; request accepted only after.
- Collision: expiry coincides with acceptance → full access sequence, then REFRESH immediately with no HREADY pulse; back-to-back expiry during a long access yields exactly one REFRESH.
- Non-default parameters: T_RCD=3, CAS_LAT=3, T_RP=1, DATA_W=16, ROW_W=13 → READ in cycle 3, capture at edge 7, out_HREADY=1 at edge 8; column zero-extended to 13 bits.

Source files
------------

// File: rtl/sdram_ctrl_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_ctrl_param_if : bus-side request signals plus SDRAM command pins      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface sdram_ctrl_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ROW_W  = 14,
    parameter int BANK_W = 2
);
    logic              in_HSEL;
    logic              in_HWRITE;
    logic [ADDR_W-1:0] in_HADDR;
    logic [DATA_W-1:0] in_HWDATA;
    logic              out_HREADY;
    logic [DATA_W-1:0] out_HRDATA;

    logic [DATA_W-1:0] in_sdram_read_data;
    logic              out_CS;
    logic              out_RAS;
    logic              out_CAS;
    logic              out_write_en;
    logic [BANK_W-1:0] out_bank_select;
    logic [ROW_W-1:0]  out_sdram_addr;
    logic [DATA_W-1:0] out_sdram_write_data;
    logic              out_ref_busy;

    // Controller side
    modport slave (
        input  in_HSEL, in_HWRITE, in_HADDR, in_HWDATA, in_sdram_read_data,
        output out_HREADY, out_HRDATA, out_CS, out_RAS, out_CAS, out_write_en,
        output out_bank_select, out_sdram_addr, out_sdram_write_data, out_ref_busy
    );

    // Bus master together with the SDRAM device model
    modport master (
        output in_HSEL, in_HWRITE, in_HADDR, in_HWDATA, in_sdram_read_data,
        input  out_HREADY, out_HRDATA, out_CS, out_RAS, out_CAS, out_write_en,
        input  out_bank_select, out_sdram_addr, out_sdram_write_data, out_ref_busy
    );
endinterface
`default_nettype wire

// File: rtl/sdram_ctrl_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_ctrl_param : closed-page SDRAM command controller with auto-refresh    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module sdram_ctrl_param #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int ROW_W        = 14,
    parameter int BANK_W       = 2,
    parameter int COL_W        = 9,
    parameter int T_RCD        = 2,
    parameter int CAS_LAT      = 2,
    parameter int T_WR         = 2,
    parameter int T_RP         = 2,
    parameter int T_RFC        = 7,
    parameter int REF_INTERVAL = 780
) (
    input  logic                 in_HCLK,
    input  logic                 in_HRESETn,
    sdram_ctrl_param_if.slave    bus
);

    localparam int REF_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [REF_W-1:0] REF_RELOAD = REF_W'(REF_INTERVAL - 1);

    localparam logic [7:0] RCD_LOAD = 8'(T_RCD - 2);
    localparam logic [7:0] CL_LOAD  = 8'(CAS_LAT - 1);
    localparam logic [7:0] WR_LOAD  = 8'(T_WR - 1);
    localparam logic [7:0] RP_LOAD  = 8'(T_RP - 2);
    localparam logic [7:0] RFC_LOAD = 8'(T_RFC - 2);

    // {CS, RAS, CAS, WE}
    localparam logic [3:0] CMD_DESELECT  = 4'b1111;
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACT       = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;

    localparam logic [ROW_W-1:0] PRE_ADDR = ROW_W'(1024);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ACT      = 4'd1,
        S_RCD_WAIT = 4'd2,
        S_RD_CMD   = 4'd3,
        S_CL_WAIT  = 4'd4,
        S_WR_CMD   = 4'd5,
        S_WR_WAIT  = 4'd6,
        S_PRE      = 4'd7,
        S_RP_WAIT  = 4'd8,
        S_REF      = 4'd9,
        S_RFC_WAIT = 4'd10
    } state_t;

    state_t             state, next_state;
    logic [7:0]         wait_cnt, wait_nxt;
    logic [REF_W-1:0]   ref_cnt;
    logic               ref_pending, pending_nxt;
    logic               expire;
    logic               accept;
    logic               capture;
    logic               done;

    logic               lat_write;
    logic [BANK_W-1:0]  lat_bank;
    logic [COL_W-1:0]   lat_col;
    logic [DATA_W-1:0]  lat_wdata;

    logic [3:0]         cmd_q, cmd_nxt;
    logic [ROW_W-1:0]   addr_q, addr_nxt;
    logic [BANK_W-1:0]  bank_q, bank_nxt;
    logic [DATA_W-1:0]  wdata_q, wdata_nxt;
    logic [DATA_W-1:0]  rdata_q, rdata_nxt;
    logic               hready_q, hready_nxt;
    logic               busy_q, busy_nxt;

    logic [ROW_W-1:0]   in_row;
    logic [BANK_W-1:0]  in_bank;
    logic [COL_W-1:0]   in_col;
    logic [ROW_W-1:0]   col_ext;

    assign in_row  = bus.in_HADDR[ROW_W-1:0];
    assign in_bank = bus.in_HADDR[ROW_W+BANK_W-1:ROW_W];
    assign in_col  = bus.in_HADDR[ROW_W+BANK_W+COL_W-1:ROW_W+BANK_W];

    generate
        if (ADDR_W > ROW_W + BANK_W + COL_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.in_HADDR[ADDR_W-1:ROW_W+BANK_W+COL_W];
        end
    endgenerate

    always_comb begin
        col_ext = '0;
        col_ext[COL_W-1:0] = lat_col;
    end

    assign expire = (ref_cnt == '0);

    // Next-state decode; wait_cnt counts down to zero in every wait state
    always_comb begin
        next_state = state;
        wait_nxt   = wait_cnt;
        accept     = 1'b0;
        capture    = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (ref_pending) begin
                    next_state = S_REF;
                end else if (bus.in_HSEL && hready_q) begin
                    accept     = 1'b1;
                    next_state = S_ACT;
                end
            end
            S_ACT: begin
                if (T_RCD == 1) begin
                    next_state = lat_write ? S_WR_CMD : S_RD_CMD;
                end else begin
                    next_state = S_RCD_WAIT;
                    wait_nxt   = RCD_LOAD;
                end
            end
            S_RCD_WAIT: begin
                if (wait_cnt == 8'd0) next_state = lat_write ? S_WR_CMD : S_RD_CMD;
                else                  wait_nxt   = wait_cnt - 8'd1;
            end
            S_RD_CMD: begin
                next_state = S_CL_WAIT;
                wait_nxt   = CL_LOAD;
            end
            S_CL_WAIT: begin
                if (wait_cnt == 8'd0) begin
                    capture    = 1'b1;
                    next_state = S_PRE;
                end else begin
                    wait_nxt = wait_cnt - 8'd1;
                end
            end
            S_WR_CMD: begin
                next_state = S_WR_WAIT;
                wait_nxt   = WR_LOAD;
            end
            S_WR_WAIT: begin
                if (wait_cnt == 8'd0) next_state = S_PRE;
                else                  wait_nxt   = wait_cnt - 8'd1;
            end
            S_PRE: begin
                if (T_RP == 1) begin
                    done = 1'b1;
                end else begin
                    next_state = S_RP_WAIT;
                    wait_nxt   = RP_LOAD;
                end
            end
            S_RP_WAIT: begin
                if (wait_cnt == 8'd0) done     = 1'b1;
                else                  wait_nxt = wait_cnt - 8'd1;
            end
            S_REF: begin
                if (T_RFC == 1) begin
                    next_state = S_IDLE;
                end else begin
                    next_state = S_RFC_WAIT;
                    wait_nxt   = RFC_LOAD;
                end
            end
            S_RFC_WAIT: begin
                if (wait_cnt == 8'd0) next_state = S_IDLE;
                else                  wait_nxt   = wait_cnt - 8'd1;
            end
            default: next_state = S_IDLE;
        endcase

        // A refresh that became due during an access goes out with no ready pulse
        if (done) next_state = ref_pending ? S_REF : S_IDLE;

        pending_nxt = ref_pending;
        if (next_state == S_REF) pending_nxt = 1'b0;
        if (expire)              pending_nxt = 1'b1;

        hready_nxt = (next_state == S_IDLE) && !pending_nxt;
        busy_nxt   = (next_state == S_REF) || (next_state == S_RFC_WAIT);
    end

    // Output decode from the state about to be entered, so pins are registered
    always_comb begin
        cmd_nxt   = CMD_NOP;
        addr_nxt  = addr_q;
        bank_nxt  = bank_q;
        wdata_nxt = wdata_q;
        rdata_nxt = rdata_q;
        case (next_state)
            S_IDLE: cmd_nxt = CMD_DESELECT;
            S_ACT: begin
                cmd_nxt  = CMD_ACT;
                addr_nxt = in_row;
                bank_nxt = in_bank;
            end
            S_RD_CMD: begin
                cmd_nxt  = CMD_READ;
                addr_nxt = col_ext;
                bank_nxt = lat_bank;
            end
            S_WR_CMD: begin
                cmd_nxt   = CMD_WRITE;
                addr_nxt  = col_ext;
                bank_nxt  = lat_bank;
                wdata_nxt = lat_wdata;
            end
            S_PRE: begin
                cmd_nxt  = CMD_PRECHARGE;
                addr_nxt = PRE_ADDR;
            end
            S_REF:   cmd_nxt = CMD_REFRESH;
            default: cmd_nxt = CMD_NOP;
        endcase
        if (capture) rdata_nxt = bus.in_sdram_read_data;
    end

    always_ff @(posedge in_HCLK or negedge in_HRESETn) begin
        if (!in_HRESETn) begin
            state       <= S_IDLE;
            wait_cnt    <= 8'd0;
            ref_cnt     <= REF_RELOAD;
            ref_pending <= 1'b0;
            lat_write   <= 1'b0;
            lat_bank    <= '0;
            lat_col     <= '0;
            lat_wdata   <= '0;
            cmd_q       <= CMD_DESELECT;
            addr_q      <= '0;
            bank_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            hready_q    <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state       <= next_state;
            wait_cnt    <= wait_nxt;
            ref_cnt     <= expire ? REF_RELOAD : ref_cnt - REF_W'(1);
            ref_pending <= pending_nxt;
            if (accept) begin
                lat_write <= bus.in_HWRITE;
                lat_bank  <= in_bank;
                lat_col   <= in_col;
                lat_wdata <= bus.in_HWDATA;
            end
            cmd_q       <= cmd_nxt;
            addr_q      <= addr_nxt;
            bank_q      <= bank_nxt;
            wdata_q     <= wdata_nxt;
            rdata_q     <= rdata_nxt;
            hready_q    <= hready_nxt;
            busy_q      <= busy_nxt;
        end
    end

    assign bus.out_CS               = cmd_q[3];
    assign bus.out_RAS              = cmd_q[2];
    assign bus.out_CAS              = cmd_q[1];
    assign bus.out_write_en         = cmd_q[0];
    assign bus.out_bank_select      = bank_q;
    assign bus.out_sdram_addr       = addr_q;
    assign bus.out_sdram_write_data = wdata_q;
    assign bus.out_HRDATA           = rdata_q;
    assign bus.out_HREADY           = hready_q;
    assign bus.out_ref_busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_ctrl_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sdram_ctrl_param : directed bench over three parameterisations           |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_sdram_ctrl_param;

    logic clk;
    logic rst_a, rst_b, rst_c;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // a: defaults; b: short refresh interval with long write recovery; c: narrow
    sdram_ctrl_param_if #(.DATA_W(32), .ADDR_W(32), .ROW_W(14), .BANK_W(2)) ifa ();
    sdram_ctrl_param_if #(.DATA_W(32), .ADDR_W(32), .ROW_W(14), .BANK_W(2)) ifb ();
    sdram_ctrl_param_if #(.DATA_W(16), .ADDR_W(32), .ROW_W(13), .BANK_W(2)) ifc ();

    sdram_ctrl_param dut_a (.in_HCLK(clk), .in_HRESETn(rst_a), .bus(ifa.slave));

    sdram_ctrl_param #(.REF_INTERVAL(20), .T_WR(30)) dut_b (
        .in_HCLK(clk), .in_HRESETn(rst_b), .bus(ifb.slave));

    sdram_ctrl_param #(.DATA_W(16), .ROW_W(13), .T_RCD(3), .CAS_LAT(3), .T_RP(1)) dut_c (
        .in_HCLK(clk), .in_HRESETn(rst_c), .bus(ifc.slave));

    logic [3:0] cmd_a, cmd_b, cmd_c;
    assign cmd_a = {ifa.out_CS, ifa.out_RAS, ifa.out_CAS, ifa.out_write_en};
    assign cmd_b = {ifb.out_CS, ifb.out_RAS, ifb.out_CAS, ifb.out_write_en};
    assign cmd_c = {ifc.out_CS, ifc.out_RAS, ifc.out_CAS, ifc.out_write_en};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int cnt;
        int ref_seen;
        int ref_at;

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        ifa.in_HSEL = 1'b0; ifa.in_HWRITE = 1'b0; ifa.in_HADDR = '0; ifa.in_HWDATA = '0;
        ifa.in_sdram_read_data = '0;
        ifb.in_HSEL = 1'b0; ifb.in_HWRITE = 1'b0; ifb.in_HADDR = '0; ifb.in_HWDATA = '0;
        ifb.in_sdram_read_data = '0;
        ifc.in_HSEL = 1'b0; ifc.in_HWRITE = 1'b0; ifc.in_HADDR = '0; ifc.in_HWDATA = '0;
        ifc.in_sdram_read_data = '0;

        step();
        chk("rst_cmd",    64'(cmd_a), 64'hF);
        chk("rst_hready", 64'(ifa.out_HREADY), 64'd1);
        chk("rst_hrdata", 64'(ifa.out_HRDATA), 64'd0);
        chk("rst_busy",   64'(ifa.out_ref_busy), 64'd0);
        chk("rst_addr",   64'(ifa.out_sdram_addr), 64'd0);

        // ---------------- default read ----------------
        step(); rst_a = 1'b1;
        step();
        ifa.in_HSEL = 1'b1; ifa.in_HWRITE = 1'b0; ifa.in_HADDR = 32'h01A58ABC;
        ifa.in_HWDATA = 32'hFFFF0000; ifa.in_sdram_read_data = 32'h0BADF00D;
        step();
        chk("rd_act_cmd",  64'(cmd_a), 64'h3);
        chk("rd_act_row",  64'(ifa.out_sdram_addr), 64'h0ABC);
        chk("rd_act_bank", 64'(ifa.out_bank_select), 64'd2);
        chk("rd_hready0",  64'(ifa.out_HREADY), 64'd0);
        ifa.in_HSEL = 1'b0; ifa.in_HADDR = '0;
        step();
        chk("rd_c1_nop", 64'(cmd_a), 64'h7);
        step();
        chk("rd_cmd",      64'(cmd_a), 64'h5);
        chk("rd_col",      64'(ifa.out_sdram_addr), 64'h1A5);
        chk("rd_col_bank", 64'(ifa.out_bank_select), 64'd2);
        step();
        chk("rd_c3_nop", 64'(cmd_a), 64'h7);
        step();
        ifa.in_sdram_read_data = 32'hDEADBEEF;
        chk("rd_c4_hrdata_old", 64'(ifa.out_HRDATA), 64'd0);
        step();
        ifa.in_sdram_read_data = 32'h0BADF00D;
        chk("rd_capture",  64'(ifa.out_HRDATA), 64'hDEADBEEF);
        chk("rd_pre_cmd",  64'(cmd_a), 64'h2);
        chk("rd_pre_addr", 64'(ifa.out_sdram_addr), 64'h400);
        step();
        chk("rd_c6_nop",    64'(cmd_a), 64'h7);
        chk("rd_c6_hready", 64'(ifa.out_HREADY), 64'd0);
        step();
        chk("rd_e7_hready", 64'(ifa.out_HREADY), 64'd1);
        chk("rd_e7_cmd",    64'(cmd_a), 64'hF);
        chk("rd_hold",      64'(ifa.out_HRDATA), 64'hDEADBEEF);

        // ---------------- default write ----------------
        ifa.in_HSEL = 1'b1; ifa.in_HWRITE = 1'b1; ifa.in_HADDR = 32'h00030005;
        ifa.in_HWDATA = 32'h12345678;
        step();
        chk("wr_act_cmd",  64'(cmd_a), 64'h3);
        chk("wr_act_row",  64'(ifa.out_sdram_addr), 64'h5);
        chk("wr_act_bank", 64'(ifa.out_bank_select), 64'd0);
        ifa.in_HSEL = 1'b0; ifa.in_HWDATA = '0; ifa.in_HADDR = '0;
        step(); step();
        chk("wr_cmd",  64'(cmd_a), 64'h4);
        chk("wr_col",  64'(ifa.out_sdram_addr), 64'h3);
        chk("wr_data", 64'(ifa.out_sdram_write_data), 64'h12345678);
        step(); step();
        chk("wr_c4_nop",  64'(cmd_a), 64'h7);
        chk("wr_c4_data", 64'(ifa.out_sdram_write_data), 64'h12345678);
        step();
        chk("wr_pre_cmd", 64'(cmd_a), 64'h2);
        step();
        chk("wr_c6_hready", 64'(ifa.out_HREADY), 64'd0);
        step();
        chk("wr_e7_hready", 64'(ifa.out_HREADY), 64'd1);
        chk("wr_e7_cmd",    64'(cmd_a), 64'hF);

        // ---------------- asynchronous reset mid-read ----------------
        ifa.in_HSEL = 1'b1; ifa.in_HWRITE = 1'b0; ifa.in_HADDR = 32'h01A58ABC;
        ifa.in_sdram_read_data = 32'h55AA55AA;
        step();
        ifa.in_HSEL = 1'b0;
        step(); step(); step();
        chk("mid_c3_nop", 64'(cmd_a), 64'h7);
        #1 rst_a = 1'b0;
        #1;
        chk("arst_cmd",    64'(cmd_a), 64'hF);
        chk("arst_hready", 64'(ifa.out_HREADY), 64'd1);
        chk("arst_hrdata", 64'(ifa.out_HRDATA), 64'd0);
        chk("arst_wdata",  64'(ifa.out_sdram_write_data), 64'd0);
        chk("arst_addr",   64'(ifa.out_sdram_addr), 64'd0);
        #1 rst_a = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cmd_a !== 4'hF || ifa.out_HREADY !== 1'b1) cnt++;
        end
        chk("post_rst_idle",   64'(cnt), 64'd0);
        chk("post_rst_hrdata", 64'(ifa.out_HRDATA), 64'd0);

        // ---------------- narrow, slower-timing instance ----------------
        step(); rst_c = 1'b1;
        step();
        ifc.in_HSEL = 1'b1; ifc.in_HWRITE = 1'b0; ifc.in_HADDR = 32'hA0FFE123;
        ifc.in_sdram_read_data = 16'h1111;
        step();
        chk("c_act_cmd",  64'(cmd_c), 64'h3);
        chk("c_act_row",  64'(ifc.out_sdram_addr), 64'h0123);
        chk("c_act_bank", 64'(ifc.out_bank_select), 64'd3);
        ifc.in_HSEL = 1'b0;
        step(); step();
        chk("c_c2_nop", 64'(cmd_c), 64'h7);
        step();
        chk("c_rd_cmd",  64'(cmd_c), 64'h5);
        chk("c_rd_col",  64'(ifc.out_sdram_addr), 64'h01FF);
        chk("c_rd_bank", 64'(ifc.out_bank_select), 64'd3);
        step(); step(); step();
        ifc.in_sdram_read_data = 16'hBEEF;
        chk("c_c6_nop",    64'(cmd_c), 64'h7);
        chk("c_c6_hrdata", 64'(ifc.out_HRDATA), 64'd0);
        step();
        ifc.in_sdram_read_data = 16'h1111;
        chk("c_capture", 64'(ifc.out_HRDATA), 64'hBEEF);
        chk("c_pre_cmd", 64'(cmd_c), 64'h2);
        chk("c_e7_hrdy", 64'(ifc.out_HREADY), 64'd0);
        step();
        chk("c_e8_hrdy", 64'(ifc.out_HREADY), 64'd1);
        chk("c_e8_cmd",  64'(cmd_c), 64'hF);

        // ---------------- refresh: interval 20, expiries at r+20k ----------------
        step(); rst_b = 1'b1;
        r = cyc;
        step_to(r + 19);
        chk("b_pre_exp_hrdy", 64'(ifb.out_HREADY), 64'd1);
        step_to(r + 20);
        chk("b_exp_hrdy", 64'(ifb.out_HREADY), 64'd0);
        chk("b_exp_cmd",  64'(cmd_b), 64'hF);
        ifb.in_HSEL = 1'b1; ifb.in_HWRITE = 1'b0; ifb.in_HADDR = 32'h01A58ABC;
        step();
        chk("b_ref_cmd",  64'(cmd_b), 64'h1);
        chk("b_ref_busy", 64'(ifb.out_ref_busy), 64'd1);
        chk("b_ref_hrdy", 64'(ifb.out_HREADY), 64'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ifb.out_ref_busy === 1'b1 && cmd_b === 4'h7 && ifb.out_HREADY === 1'b0) cnt++;
        end
        chk("b_rfc_nops", 64'(cnt), 64'd6);
        step();
        chk("b_rfc_end_hrdy", 64'(ifb.out_HREADY), 64'd1);
        chk("b_rfc_end_busy", 64'(ifb.out_ref_busy), 64'd0);
        chk("b_rfc_end_cmd",  64'(cmd_b), 64'hF);
        step();
        chk("b_accept_after", 64'(cmd_b), 64'h3);
        ifb.in_HSEL = 1'b0;
        step_to(r + 36);
        chk("b_rd1_done", 64'(ifb.out_HREADY), 64'd1);

        // collision: acceptance on the expiry edge r+40
        step_to(r + 39);
        ifb.in_HSEL = 1'b1; ifb.in_HWRITE = 1'b0;
        step();
        chk("b_col_act", 64'(cmd_b), 64'h3);
        ifb.in_HSEL = 1'b0;
        step_to(r + 46);
        chk("b_col_c6_nop", 64'(cmd_b), 64'h7);
        step();
        chk("b_col_ref",  64'(cmd_b), 64'h1);
        chk("b_col_hrdy", 64'(ifb.out_HREADY), 64'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ifb.out_HREADY !== 1'b0) cnt++;
        end
        chk("b_col_no_pulse", 64'(cnt), 64'd0);
        step();
        chk("b_col_end_hrdy", 64'(ifb.out_HREADY), 64'd1);

        // long write spanning expiries at r+60 and r+80
        ifb.in_HSEL = 1'b1; ifb.in_HWRITE = 1'b1; ifb.in_HADDR = 32'h00030005;
        ifb.in_HWDATA = 32'hCAFEF00D;
        step();
        chk("b_wr_act", 64'(cmd_b), 64'h3);
        ifb.in_HSEL = 1'b0; ifb.in_HWDATA = '0;
        ref_seen = 0;
        ref_at   = 0;
        cnt      = 0;
        while (cyc < r + 97) begin
            step();
            if (cmd_b === 4'h1) begin
                ref_seen++;
                if (ref_at == 0) ref_at = cyc - r;
            end
            if (cyc < r + 97 && ifb.out_HREADY !== 1'b0) cnt++;
            if (cyc == r + 57) chk("b_wr_data", 64'(ifb.out_sdram_write_data), 64'hCAFEF00D);
        end
        chk("b_one_refresh", 64'(ref_seen), 64'd1);
        chk("b_refresh_at",  64'(ref_at), 64'd90);
        chk("b_wr_no_ready", 64'(cnt), 64'd0);
        chk("b_wr_end_hrdy", 64'(ifb.out_HREADY), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
